// File: rtl/duck_motion.sv
// Sprite motion controller for one duck: launch, bouncing flight with wing flap,
// hit freeze, fall or escape. One update per video frame (falling edge of vsync).
module duck_motion #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int X_MAX       = 640,
  parameter int GROUND      = 400,
  parameter int SPEED_X     = 2,
  parameter int SPEED_Y     = 2,
  parameter int FALL_SPEED  = 4,
  parameter int FLAP_FRAMES = 8,
  parameter int HIT_FRAMES  = 30,
  parameter int FLY_FRAMES  = 300,
  parameter int BASE_SEL    = 0
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start,
  input  logic [9:0] start_x,
  input  logic       start_left,
  input  logic       hit,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic [4:0] sprite_sel,
  output logic       sprite_attr,
  output logic       sprite_pos,
  output logic       sprite_vis,
  output logic       busy,
  output logic       escaped,
  output logic       fallen
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLY    = 3'd1,
    HIT    = 3'd2,
    FALL   = 3'd3,
    ESCAPE = 3'd4
  } state_t;

  localparam logic [10:0] X_LIM     = 11'(X_MAX - SPRITE_W);
  localparam logic [10:0] Y_LIM     = 11'(GROUND - SPRITE_H);
  localparam logic [10:0] X_STEP    = 11'(SPEED_X);
  localparam logic [10:0] Y_STEP    = 11'(SPEED_Y);
  localparam logic [10:0] F_STEP    = 11'(FALL_SPEED);
  localparam logic [4:0]  SEL_WING0 = 5'(BASE_SEL);
  localparam logic [4:0]  SEL_WING1 = 5'(BASE_SEL + 1);
  localparam logic [4:0]  SEL_HIT   = 5'(BASE_SEL + 2);
  localparam logic [4:0]  SEL_FALL  = 5'(BASE_SEL + 3);
  localparam logic [15:0] FLAP_LAST = 16'(FLAP_FRAMES - 1);
  localparam logic [15:0] HIT_LAST  = 16'(HIT_FRAMES - 1);
  localparam logic [15:0] FLY_LAST  = 16'(FLY_FRAMES - 1);

  state_t      state;
  logic        vsync_q;
  logic        tick;
  logic        dx;
  logic        dy_up;
  logic [15:0] flap_cnt;
  logic [15:0] hit_cnt;
  logic [15:0] fly_cnt;

  logic [10:0] x_sum, y_sum, y_fall_sum, y_esc_sum;
  logic [10:0] x_fly, y_fly, y_fall, y_esc;
  logic        dx_fly, dy_up_fly;
  logic [4:0]  sel_flap;
  logic [15:0] flap_next;
  logic [9:0]  x_launch;

  assign tick        = vsync_q & ~vsync;
  assign sprite_attr = dx;

  // Candidate next-frame position, direction and wing frame for the moving states.
  // Sums are 11 bits wide so that bit 10 flags a step past zero.
  always_comb begin
    x_sum      = 11'd0;
    y_sum      = 11'd0;
    y_fall_sum = 11'd0;
    y_esc_sum  = 11'd0;
    x_fly      = 11'd0;
    y_fly      = 11'd0;
    y_fall     = 11'd0;
    y_esc      = 11'd0;
    dx_fly     = dx;
    dy_up_fly  = dy_up;
    sel_flap   = sprite_sel;
    flap_next  = 16'd0;
    x_launch   = start_x;

    if (dx) begin
      x_sum = {1'b0, sprite_x} - X_STEP;
    end else begin
      x_sum = {1'b0, sprite_x} + X_STEP;
    end
    if (x_sum[10] || x_sum == 11'd0) begin
      x_fly  = 11'd0;
      dx_fly = ~dx;
    end else if (x_sum >= X_LIM) begin
      x_fly  = X_LIM;
      dx_fly = ~dx;
    end else begin
      x_fly  = x_sum;
      dx_fly = dx;
    end

    if (dy_up) begin
      y_sum = {2'b00, sprite_y} - Y_STEP;
    end else begin
      y_sum = {2'b00, sprite_y} + Y_STEP;
    end
    if (y_sum[10] || y_sum == 11'd0) begin
      y_fly     = 11'd0;
      dy_up_fly = ~dy_up;
    end else if (y_sum >= Y_LIM) begin
      y_fly     = Y_LIM;
      dy_up_fly = ~dy_up;
    end else begin
      y_fly     = y_sum;
      dy_up_fly = dy_up;
    end

    y_fall_sum = {2'b00, sprite_y} + F_STEP;
    if (y_fall_sum >= Y_LIM) begin
      y_fall = Y_LIM;
    end else begin
      y_fall = y_fall_sum;
    end

    y_esc_sum = {2'b00, sprite_y} - Y_STEP;
    if (y_esc_sum[10] || y_esc_sum == 11'd0) begin
      y_esc = 11'd0;
    end else begin
      y_esc = y_esc_sum;
    end

    if (flap_cnt == FLAP_LAST) begin
      flap_next = 16'd0;
      if (sprite_sel == SEL_WING0) begin
        sel_flap = SEL_WING1;
      end else begin
        sel_flap = SEL_WING0;
      end
    end else begin
      flap_next = flap_cnt + 16'd1;
      sel_flap  = sprite_sel;
    end

    if ({1'b0, start_x} > X_LIM) begin
      x_launch = X_LIM[9:0];
    end else begin
      x_launch = start_x;
    end
  end

  // Duck state machine; all sprite outputs are registered here.
  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vsync_q    <= 1'b1;
      dx         <= 1'b0;
      dy_up      <= 1'b1;
      flap_cnt   <= 16'd0;
      hit_cnt    <= 16'd0;
      fly_cnt    <= 16'd0;
      sprite_x   <= 10'd0;
      sprite_y   <= 9'd0;
      sprite_sel <= 5'd0;
      sprite_pos <= 1'b0;
      sprite_vis <= 1'b0;
      busy       <= 1'b0;
      escaped    <= 1'b0;
      fallen     <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      sprite_pos <= 1'b0;
      escaped    <= 1'b0;
      fallen     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FLY;
            sprite_x   <= x_launch;
            sprite_y   <= Y_LIM[8:0];
            dx         <= start_left;
            dy_up      <= 1'b1;
            flap_cnt   <= 16'd0;
            fly_cnt    <= 16'd0;
            hit_cnt    <= 16'd0;
            sprite_sel <= SEL_WING0;
            sprite_vis <= 1'b1;
            sprite_pos <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FLY: begin
          if (hit) begin
            state      <= HIT;
            sprite_sel <= SEL_HIT;
            hit_cnt    <= 16'd0;
            sprite_pos <= 1'b1;
          end else if (tick) begin
            sprite_x   <= x_fly[9:0];
            sprite_y   <= y_fly[8:0];
            dx         <= dx_fly;
            dy_up      <= dy_up_fly;
            flap_cnt   <= flap_next;
            sprite_sel <= sel_flap;
            fly_cnt    <= fly_cnt + 16'd1;
            sprite_pos <= 1'b1;
            if (fly_cnt == FLY_LAST) begin
              state <= ESCAPE;
            end
          end
        end
        HIT: begin
          if (tick) begin
            if (hit_cnt == HIT_LAST) begin
              state      <= FALL;
              sprite_sel <= SEL_FALL;
              sprite_pos <= 1'b1;
            end else begin
              hit_cnt <= hit_cnt + 16'd1;
            end
          end
        end
        FALL: begin
          if (tick) begin
            sprite_y   <= y_fall[8:0];
            sprite_pos <= 1'b1;
            if (y_fall == Y_LIM) begin
              state      <= IDLE;
              sprite_vis <= 1'b0;
              busy       <= 1'b0;
              fallen     <= 1'b1;
            end
          end
        end
        ESCAPE: begin
          if (tick) begin
            sprite_y   <= y_esc[8:0];
            flap_cnt   <= flap_next;
            sprite_sel <= sel_flap;
            sprite_pos <= 1'b1;
            if (y_esc == 11'd0) begin
              state      <= IDLE;
              sprite_vis <= 1'b0;
              busy       <= 1'b0;
              escaped    <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          sprite_vis <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duck_motion.sv
// Directed bench for duck_motion: launch, flap, bounce, hit/fall, escape, reset
// abort and ignored inputs, with hand-computed expectations.
module tb_duck_motion;

  logic       clk_25mhz = 1'b0;
  logic       rst = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic [9:0] start_x = 10'd0;
  logic       start_left = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic [4:0] sprite_sel;
  logic       sprite_attr, sprite_pos, sprite_vis, busy, escaped, fallen;

  int checks = 0;
  int errors = 0;
  int n, cnt;
  logic pos_hi, pos_lo, esc_hi, esc_lo, fall_hi, fall_lo, busy_hi;

  duck_motion dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .vsync      (vsync),
    .start      (start),
    .start_x    (start_x),
    .start_left (start_left),
    .hit        (hit),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_sel (sprite_sel),
    .sprite_attr(sprite_attr),
    .sprite_pos (sprite_pos),
    .sprite_vis (sprite_vis),
    .busy       (busy),
    .escaped    (escaped),
    .fallen     (fallen)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] sx, input logic left);
    @(negedge clk_25mhz);
    start = 1'b1; start_x = sx; start_left = left;
    @(negedge clk_25mhz);
    start = 1'b0;
  endtask

  // One video frame: vsync low for one cycle, samples around the update edge.
  task automatic frame();
    @(negedge clk_25mhz);
    vsync = 1'b0;
    @(negedge clk_25mhz);
    pos_hi = sprite_pos; esc_hi = escaped; fall_hi = fallen; busy_hi = busy;
    vsync = 1'b1;
    @(negedge clk_25mhz);
    pos_lo = sprite_pos; esc_lo = escaped; fall_lo = fallen;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_25mhz);
    check("rst_x", 32'(sprite_x), 32'd0);
    check("rst_y", 32'(sprite_y), 32'd0);
    check("rst_vis", 32'(sprite_vis), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({escaped, fallen, sprite_pos, sprite_attr}), 32'd0);
    rst = 1'b1;

    // Launch at 100 moving right, then hit coincident with frame 10
    launch(10'd100, 1'b0);
    check("launch_x", 32'(sprite_x), 32'd100);
    check("launch_y", 32'(sprite_y), 32'd368);
    check("launch_vis", 32'(sprite_vis), 32'd1);
    check("launch_sel", 32'(sprite_sel), 32'd0);
    check("launch_attr", 32'(sprite_attr), 32'd0);
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_pos", 32'(sprite_pos), 32'd1);
    frame();
    check("t1_x", 32'(sprite_x), 32'd102);
    check("t1_y", 32'(sprite_y), 32'd366);
    check("t1_pos_hi", 32'(pos_hi), 32'd1);
    check("t1_pos_lo", 32'(pos_lo), 32'd0);
    repeat (6) frame();
    check("t7_sel", 32'(sprite_sel), 32'd0);
    frame();
    check("t8_sel", 32'(sprite_sel), 32'd1);
    frame();
    check("t9_x", 32'(sprite_x), 32'd118);
    check("t9_y", 32'(sprite_y), 32'd350);
    launch(10'd500, 1'b1);
    check("start_busy_x", 32'(sprite_x), 32'd118);
    check("start_busy_pos", 32'(sprite_pos), 32'd0);
    check("start_busy_attr", 32'(sprite_attr), 32'd0);
    @(negedge clk_25mhz);
    vsync = 1'b0; hit = 1'b1;
    @(negedge clk_25mhz);
    hit = 1'b0; vsync = 1'b1;
    check("hit_sel", 32'(sprite_sel), 32'd2);
    check("hit_x", 32'(sprite_x), 32'd118);
    check("hit_y", 32'(sprite_y), 32'd350);
    repeat (29) frame();
    check("hit29_sel", 32'(sprite_sel), 32'd2);
    check("hit29_y", 32'(sprite_y), 32'd350);
    frame();
    check("hit30_sel", 32'(sprite_sel), 32'd3);
    check("hit30_pos", 32'(pos_hi), 32'd1);
    repeat (4) frame();
    check("fall4_y", 32'(sprite_y), 32'd366);
    check("fall4_fallen", 32'(fall_hi), 32'd0);
    check("fall4_busy", 32'(busy), 32'd1);
    frame();
    check("fall5_y", 32'(sprite_y), 32'd368);
    check("fall5_fallen", 32'(fall_hi), 32'd1);
    check("fall5_busy", 32'(busy_hi), 32'd0);
    check("fall5_vis", 32'(sprite_vis), 32'd0);
    check("fallen_once", 32'(fall_lo), 32'd0);

    // Hit while idle is ignored; outputs hold
    @(negedge clk_25mhz);
    hit = 1'b1;
    @(negedge clk_25mhz);
    hit = 1'b0;
    check("idle_hit_busy", 32'(busy), 32'd0);
    check("idle_hit_pos", 32'(sprite_pos), 32'd0);
    check("idle_hold_x", 32'(sprite_x), 32'd118);
    check("idle_hold_sel", 32'(sprite_sel), 32'd3);

    // Right-edge bounce, then vsync stuck low
    launch(10'd606, 1'b0);
    check("b0_x", 32'(sprite_x), 32'd606);
    frame();
    check("b1_x", 32'(sprite_x), 32'd608);
    check("b1_attr", 32'(sprite_attr), 32'd1);
    frame();
    check("b2_x", 32'(sprite_x), 32'd606);
    check("b2_y", 32'(sprite_y), 32'd364);
    cnt = 0;
    @(negedge clk_25mhz);
    vsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_25mhz);
      if (sprite_pos) cnt++;
    end
    vsync = 1'b1;
    check("stuck_low_moves", 32'(cnt), 32'd1);
    check("stuck_low_x", 32'(sprite_x), 32'd604);

    // Reset mid-flight aborts at once
    @(negedge clk_25mhz);
    #5 rst = 1'b0;
    #1;
    check("abort_x", 32'(sprite_x), 32'd0);
    check("abort_y", 32'(sprite_y), 32'd0);
    check("abort_vis_busy", 32'({sprite_vis, busy, sprite_attr}), 32'd0);
    check("abort_pulses", 32'({escaped, fallen, sprite_pos}), 32'd0);
    repeat (2) @(negedge clk_25mhz);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      if (pos_hi || pos_lo) cnt++;
    end
    check("post_reset_pos", 32'(cnt), 32'd0);

    // Launch beyond the right limit is clamped
    launch(10'd700, 1'b0);
    check("clamp_x", 32'(sprite_x), 32'd608);
    @(negedge clk_25mhz);
    rst = 1'b0;
    @(negedge clk_25mhz);
    rst = 1'b1;

    // Full flight to escape
    launch(10'd100, 1'b0);
    repeat (7) frame();
    check("f7_sel", 32'(sprite_sel), 32'd0);
    frame();
    check("f8_sel", 32'(sprite_sel), 32'd1);
    repeat (8) frame();
    check("f16_sel", 32'(sprite_sel), 32'd0);
    repeat (284) frame();
    check("f300_x", 32'(sprite_x), 32'd516);
    check("f300_y", 32'(sprite_y), 32'd232);
    check("f300_sel", 32'(sprite_sel), 32'd1);
    frame();
    check("e1_y", 32'(sprite_y), 32'd230);
    check("e1_x", 32'(sprite_x), 32'd516);
    @(negedge clk_25mhz);
    hit = 1'b1;
    @(negedge clk_25mhz);
    hit = 1'b0;
    check("esc_hit_pos", 32'(sprite_pos), 32'd0);
    check("esc_hit_busy", 32'(busy), 32'd1);
    check("esc_hit_sel", 32'(sprite_sel), 32'd1);
    n = 0;
    esc_hi = 1'b0;
    while (n < 200 && esc_hi !== 1'b1) begin
      frame();
      n++;
    end
    check("esc_frames", 32'(n), 32'd115);
    check("esc_y", 32'(sprite_y), 32'd0);
    check("esc_x", 32'(sprite_x), 32'd516);
    check("esc_busy", 32'(busy_hi), 32'd0);
    check("esc_vis", 32'(sprite_vis), 32'd0);
    check("esc_sel", 32'(sprite_sel), 32'd0);
    check("escaped_once", 32'(esc_lo), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
